pcie_bram_bank: RTL and testbench

//  Parametrised simple-dual-port buffer RAM for PCIe core RX/TX TLP storage; successor to the fixed 72b x 2K buffer.

---
 rtl/pcie_bram_pkg.sv | 28 ++
 rtl/pcie_bram_lane_mem.sv | 27 ++
 rtl/pcie_bram_bank.sv | 112 +++++++++++
 tb/tb_pcie_bram_bank.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_bram_pkg.sv
// Shared constants and helpers for the PCIe TLP buffer RAM bank.
// Optional feature macro used by pcie_bram_bank: PCIE_BRAM_BYPASS_EN.
package pcie_bram_pkg;

    // Default lane geometry matches a 7-series BRAM byte plus parity bit
    localparam int LANE_W_DEF    = 9;
    localparam int NUM_LANES_DEF = 8;

    // The only read latencies the pipeline supports
    localparam int RD_LAT_SHORT = 1;
    localparam int RD_LAT_LONG  = 2;

    // Full word width derived from lane geometry
    function automatic int data_w(input int lane_w, input int num_lanes);
        return lane_w * num_lanes;
    endfunction

    localparam int DATA_W_DEF = data_w(LANE_W_DEF, NUM_LANES_DEF);

    typedef logic [LANE_W_DEF-1:0] lane_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    // Extract lane k from a default-geometry word
    function automatic lane_t lane_sel(input word_t word, input int unsigned k);
        return word[k*LANE_W_DEF +: LANE_W_DEF];
    endfunction

endpackage

// File: rtl/pcie_bram_lane_mem.sv
// One lane of the buffer: LANE_W x 2**DEPTH_LOG2 storage with a
// synchronous write port and an asynchronous read port.
// The array is deliberately never reset.
module pcie_bram_lane_mem #(
    parameter int LANE_W     = 9,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  user_clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [LANE_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [LANE_W-1:0]     rdata
);

    logic [LANE_W-1:0] mem [2**DEPTH_LOG2];

    // Store the lane on a qualified write strobe
    always_ff @(posedge user_clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pcie_bram_bank.sv
// Parametrised simple-dual-port TLP buffer RAM with per-lane write enables,
// 1- or 2-cycle read latency, output clock enable and read-valid flag.
// Define PCIE_BRAM_BYPASS_EN for write-first collision behaviour; otherwise
// a same-address read and write returns the old contents (read-first).
module pcie_bram_bank
    import pcie_bram_pkg::*;
#(
    parameter int LANE_W     = LANE_W_DEF,
    parameter int NUM_LANES  = NUM_LANES_DEF,
    parameter int ADDR_W     = 13,
    parameter int DEPTH_LOG2 = 11,
    parameter int RD_LAT     = RD_LAT_LONG
) (
    input  logic                        user_clk_i,
    input  logic                        reset_n_i,
    input  logic                        wen,
    input  logic [NUM_LANES-1:0]        wbe,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [LANE_W*NUM_LANES-1:0] wdata,
    input  logic                        ren,
    input  logic                        rce,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [LANE_W*NUM_LANES-1:0] rdata,
    output logic                        rvalid
);

    localparam int DATA_W = data_w(LANE_W, NUM_LANES);

    if (RD_LAT != RD_LAT_SHORT && RD_LAT != RD_LAT_LONG) begin : g_bad_rd_lat
        $error("pcie_bram_bank: RD_LAT must be 1 or 2");
    end
    if (DEPTH_LOG2 > ADDR_W) begin : g_bad_depth
        $error("pcie_bram_bank: DEPTH_LOG2 must not exceed ADDR_W");
    end

    logic [DEPTH_LOG2-1:0] wa_lo;
    logic [DEPTH_LOG2-1:0] ra_lo;
    logic [DATA_W-1:0]     mem_rd;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     d1;
    logic                  v1;
    logic                  unused_ok;

    // Upper address bits alias onto the stored depth
    assign wa_lo = waddr[DEPTH_LOG2-1:0];
    assign ra_lo = raddr[DEPTH_LOG2-1:0];

    // Upper address bits and rce (in the 1-cycle build) are intentionally ignored
    assign unused_ok = ^{waddr, raddr, rce};

`ifdef PCIE_BRAM_BYPASS_EN
    logic collide;
    assign collide = wen & ren & (wa_lo == ra_lo);
`endif

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        pcie_bram_lane_mem #(
            .LANE_W     (LANE_W),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_lane_mem (
            .user_clk_i (user_clk_i),
            .we         (reset_n_i & wen & wbe[k]),
            .waddr      (wa_lo),
            .wdata      (wdata[k*LANE_W +: LANE_W]),
            .raddr      (ra_lo),
            .rdata      (mem_rd[k*LANE_W +: LANE_W])
        );

`ifdef PCIE_BRAM_BYPASS_EN
        assign rd_word[k*LANE_W +: LANE_W] = (collide & wbe[k]) ? wdata[k*LANE_W +: LANE_W]
                                                                : mem_rd[k*LANE_W +: LANE_W];
`else
        assign rd_word[k*LANE_W +: LANE_W] = mem_rd[k*LANE_W +: LANE_W];
`endif
    end

    // Stage 1: capture the array word on ren; data holds otherwise, valid is a pulse
    always_ff @(posedge user_clk_i) begin
        if (!reset_n_i) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else if (ren) begin
            d1 <= rd_word;
            v1 <= 1'b1;
        end else begin
            v1 <= 1'b0;
        end
    end

    if (RD_LAT == RD_LAT_LONG) begin : g_stage2
        logic [DATA_W-1:0] d2;
        logic              v2;

        // Stage 2: output register advancing only when rce allows
        always_ff @(posedge user_clk_i) begin
            if (!reset_n_i) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else if (rce) begin
                d2 <= d1;
                v2 <= v1;
            end
        end

        assign rdata  = d2;
        assign rvalid = v2;
    end else begin : g_stage1_out
        assign rdata  = d1;
        assign rvalid = v1;
    end

endmodule

// File: tb/tb_pcie_bram_bank.sv
// Directed, table-driven bench for pcie_bram_bank at default parameters
// (72-bit words, 2K deep, RD_LAT=2). Expected collision data follows
// PCIE_BRAM_BYPASS_EN when it is defined for the build.
module tb_pcie_bram_bank;
    import pcie_bram_pkg::*;

    logic        user_clk_i = 1'b0;
    logic        reset_n_i  = 1'b0;
    logic        wen        = 1'b0;
    logic [7:0]  wbe        = '0;
    logic [12:0] waddr      = '0;
    logic [71:0] wdata      = '0;
    logic        ren        = 1'b0;
    logic        rce        = 1'b0;
    logic [12:0] raddr      = '0;
    logic [71:0] rdata;
    logic        rvalid;

    int errors = 0;
    int checks = 0;

    always #5 user_clk_i = ~user_clk_i;

    pcie_bram_bank #(
        .LANE_W     (9),
        .NUM_LANES  (8),
        .ADDR_W     (13),
        .DEPTH_LOG2 (11),
        .RD_LAT     (2)
    ) dut (
        .user_clk_i (user_clk_i),
        .reset_n_i  (reset_n_i),
        .wen        (wen),
        .wbe        (wbe),
        .waddr      (waddr),
        .wdata      (wdata),
        .ren        (ren),
        .rce        (rce),
        .raddr      (raddr),
        .rdata      (rdata),
        .rvalid     (rvalid)
    );

    typedef struct {
        logic        wen;
        logic [7:0]  wbe;
        logic [12:0] waddr;
        logic [71:0] wdata;
        logic        ren;
        logic        rce;
        logic [12:0] raddr;
        logic        exp_rvalid;
        logic [71:0] exp_rdata;
    } vec_t;

    localparam logic [71:0] D5   = 72'h0FF0FF0FF0FF0FF000;
    localparam logic [71:0] ONES = {72{1'b1}};
    localparam logic [71:0] PART = 72'hFFFFFFFFF_000000000;
    localparam logic [71:0] VA   = 72'h123456789ABCDEF012;
    localparam logic [71:0] X0   = 72'h111111111111111111;
    localparam logic [71:0] X1   = 72'h222222222222222222;
    localparam logic [71:0] X2   = 72'h333333333333333333;
    localparam logic [71:0] VB   = 72'hABCDEF0123456789AB;
    localparam logic [71:0] VC   = 72'h5A5A5A5A5A5A5A5A5A;
    localparam logic [71:0] VE   = 72'h3C3C3C3C3C3C3C3C3C;

    vec_t vecs[14];

    function automatic vec_t mk(input logic w, input logic [7:0] be, input logic [12:0] wa,
                                input logic [71:0] wd, input logic r, input logic ce,
                                input logic [12:0] ra, input logic ev, input logic [71:0] ed);
        vec_t v;
        v.wen = w; v.wbe = be; v.waddr = wa; v.wdata = wd;
        v.ren = r; v.rce = ce; v.raddr = ra;
        v.exp_rvalid = ev; v.exp_rdata = ed;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst_n, input logic w, input logic [7:0] be,
                                 input logic [12:0] wa, input logic [71:0] wd,
                                 input logic r, input logic ce, input logic [12:0] ra);
        reset_n_i = rst_n;
        wen = w; wbe = be; waddr = wa; wdata = wd;
        ren = r; rce = ce; raddr = ra;
        @(posedge user_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_rv, input logic [71:0] exp_rd);
        checks++;
        if (rvalid !== exp_rv) begin
            errors++;
            $display("[TB] FAIL %s rvalid: got %0b expected %0b", name, rvalid, exp_rv);
        end
        checks++;
        if (rdata !== exp_rd) begin
            errors++;
            $display("[TB] FAIL %s rdata: got %h expected %h", name, rdata, exp_rd);
        end
    endtask

    task automatic idle(input string name, input logic ce, input logic exp_rv, input logic [71:0] exp_rd);
        applyStimulus(1'b1, 1'b0, 8'h00, 13'h0, 72'h0, 1'b0, ce, 13'h0);
        checkOutput(name, exp_rv, exp_rd);
    endtask

    logic [71:0] coll_full;
    logic [71:0] merged;
    logic [71:0] coll_part;

    initial begin
        // Full-word collision result, and partial (upper lanes) write-first merge
        for (int k = 0; k < 8; k++) begin
            merged[k*9 +: 9] = (k >= 4) ? lane_sel(VE, k) : lane_sel(VC, k);
        end
`ifdef PCIE_BRAM_BYPASS_EN
        coll_full = VC;
        coll_part = merged;
`else
        coll_full = VB;
        coll_part = VC;
`endif

        vecs[0]  = mk(1, 8'hFF, 13'd5,     D5,    0, 1, 13'd0,     0, 72'h0);
        vecs[1]  = mk(0, 8'h00, 13'd0,     72'h0, 1, 1, 13'd5,     0, 72'h0);
        vecs[2]  = mk(0, 8'h00, 13'd0,     72'h0, 0, 1, 13'd0,     1, D5);
        vecs[3]  = mk(0, 8'h00, 13'd0,     72'h0, 0, 1, 13'd0,     0, D5);
        vecs[4]  = mk(1, 8'hFF, 13'd7,     ONES,  0, 1, 13'd0,     0, D5);
        vecs[5]  = mk(1, 8'h0F, 13'd7,     72'h0, 0, 1, 13'd0,     0, D5);
        vecs[6]  = mk(0, 8'h00, 13'd0,     72'h0, 1, 1, 13'd7,     0, D5);
        vecs[7]  = mk(0, 8'h00, 13'd0,     72'h0, 0, 1, 13'd0,     1, PART);
        vecs[8]  = mk(1, 8'h00, 13'd7,     72'h0, 0, 1, 13'd0,     0, PART);
        vecs[9]  = mk(0, 8'h00, 13'd0,     72'h0, 1, 1, 13'd7,     0, PART);
        vecs[10] = mk(0, 8'h00, 13'd0,     72'h0, 0, 1, 13'd0,     1, PART);
        vecs[11] = mk(1, 8'hFF, 13'h0803,  VA,    0, 1, 13'd0,     0, PART);
        vecs[12] = mk(0, 8'h00, 13'd0,     72'h0, 1, 1, 13'h0003,  0, PART);
        vecs[13] = mk(0, 8'h00, 13'd0,     72'h0, 0, 1, 13'd0,     1, VA);

        // Reset for two cycles, then ten idle cycles with nothing valid
        applyStimulus(1'b0, 0, 8'h00, 13'h0, 72'h0, 0, 1, 13'h0);
        checkOutput("reset_c1", 1'b0, 72'h0);
        applyStimulus(1'b0, 0, 8'h00, 13'h0, 72'h0, 0, 1, 13'h0);
        checkOutput("reset_c2", 1'b0, 72'h0);
        for (int i = 0; i < 10; i++) begin
            idle($sformatf("idle%0d", i), 1'b1, 1'b0, 72'h0);
        end

        // Write/read, partial write, wbe=0 no-op and address aliasing
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].wen, vecs[i].wbe, vecs[i].waddr, vecs[i].wdata,
                          vecs[i].ren, vecs[i].rce, vecs[i].raddr);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_rvalid, vecs[i].exp_rdata);
        end

        // Stall: stage 2 frozen while rce=0, X1 overwritten in stage 1 and lost
        applyStimulus(1'b1, 1, 8'hFF, 13'd20, X0, 0, 1, 13'd0);
        checkOutput("stall_w0", 1'b0, VA);
        applyStimulus(1'b1, 1, 8'hFF, 13'd21, X1, 0, 1, 13'd0);
        checkOutput("stall_w1", 1'b0, VA);
        applyStimulus(1'b1, 1, 8'hFF, 13'd22, X2, 0, 1, 13'd0);
        checkOutput("stall_w2", 1'b0, VA);
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 1, 13'd20);
        checkOutput("stall_r0", 1'b0, VA);
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 1, 13'd21);
        checkOutput("stall_r1", 1'b1, X0);
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 0, 13'd22);
        checkOutput("stall_hold1", 1'b1, X0);
        idle("stall_hold2", 1'b0, 1'b1, X0);
        idle("stall_resume", 1'b1, 1'b0, X2);

        // Collision at addr 9: full-word write, then upper-lane-only write
        applyStimulus(1'b1, 1, 8'hFF, 13'd9, VB, 0, 1, 13'd0);
        checkOutput("coll_prewrite", 1'b0, X2);
        applyStimulus(1'b1, 1, 8'hFF, 13'd9, VC, 1, 1, 13'd9);
        checkOutput("coll_launch", 1'b0, X2);
        idle("coll_full", 1'b1, 1'b1, coll_full);
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 1, 13'd9);
        checkOutput("coll_reread_l", 1'b0, coll_full);
        idle("coll_reread", 1'b1, 1'b1, VC);
        applyStimulus(1'b1, 1, 8'hF0, 13'd9, VE, 1, 1, 13'd9);
        checkOutput("collp_launch", 1'b0, VC);
        idle("collp_data", 1'b1, 1'b1, coll_part);
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 1, 13'd9);
        checkOutput("collp_reread_l", 1'b0, coll_part);
        idle("collp_reread", 1'b1, 1'b1, merged);

        // Reset with reads in flight; write during reset must be ignored
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 1, 13'd5);
        checkOutput("rst_flight_l", 1'b0, merged);
        applyStimulus(1'b0, 1, 8'hFF, 13'd5, 72'h0, 1, 1, 13'd7);
        checkOutput("rst_flight_drop", 1'b0, 72'h0);
        applyStimulus(1'b0, 0, 8'h00, 13'd0, 72'h0, 0, 1, 13'd0);
        checkOutput("rst_flight_hold", 1'b0, 72'h0);
        applyStimulus(1'b1, 0, 8'h00, 13'd0, 72'h0, 1, 1, 13'd5);
        checkOutput("rst_after_l", 1'b0, 72'h0);
        idle("rst_after_mem", 1'b1, 1'b1, D5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
